game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Top-level game-flow FSM, the multi-level/multi-life successor of the single-round
//  start/play/win/lose controller. Tracks level, remaining lives and a per-round
//  countdown timer. Sits between the input/debounce logic and the VGA/score display.
//  Display logic reads the one-hot state flags and the counters directly.
// PARAMETERS
//  NUM_LEVELS   3    levels to clear before WIN (>=1)
//  NUM_LIVES    3    lives loaded at game start (>=1)
//  TIMER_W      8    width of round countdown timer
//  ROUND_TICKS  100  timer reload value per round (< 2**TIMER_W)
// PORTS
//  clk          in   1            system clock
//  reset        in   1            async, active-high
//  start_btn    in   1            debounced start/continue button, level-sensitive
//  tick         in   1            1-cycle timer strobe (e.g. 1 Hz enable)
//  win          in   1            round-cleared event from game logic
//  lose         in   1            round-failed event from game logic
//  pause_btn    in   1            debounced pause button (only with GAME_PAUSE_EN)
//  q_start      out  1            one-hot state flags (exactly one high)
//  q_playing    out  1
//  q_level_clr  out  1
//  q_life_lost  out  1
//  q_game_over  out  1
//  q_win        out  1
//  q_paused     out  1            only with GAME_PAUSE_EN
//  level        out  LEVEL_W      current level, 0-based; LEVEL_W=max(1,$clog2(NUM_LEVELS))
//  lives        out  LIVES_W      remaining lives; LIVES_W=$clog2(NUM_LIVES+1)
//  timer        out  TIMER_W      remaining round ticks
//  round_start  out  1            1-cycle pulse on every entry into PLAYING from a non-PAUSED state
// BEHAVIOUR
//  - Reset: state=START, level=0, lives=NUM_LIVES, timer=ROUND_TICKS, round_start=0,
//    btn_prev regs=1 (a button held through reset does not trigger).
//  - Button event = btn & ~btn_prev, registered prev; all transitions use events, not levels.
//  - All outputs registered; state change visible 1 cycle after the qualifying input edge.
//  - START: start evt -> PLAYING; load level=0, lives=NUM_LIVES, timer=ROUND_TICKS.
//  - PLAYING: tick & timer!=0 -> timer-1; timer saturates at 0. fail = lose | (timer==0).
//    Priority win > fail. win: level==NUM_LEVELS-1 -> WIN, else -> LEVEL_CLR.
//    fail: lives-1; if lives==1 -> GAME_OVER (lives=0), else -> LIFE_LOST.
//  - LEVEL_CLR: start evt -> PLAYING, level+1, timer=ROUND_TICKS.
//  - LIFE_LOST: start evt -> PLAYING, level unchanged, timer=ROUND_TICKS.
//  - GAME_OVER, WIN: start evt -> START; counters hold until START exits.
//  - win/lose/tick are ignored outside PLAYING. The timer is frozen outside PLAYING.
//  - Reset mid-game returns to START within the same cycle (async). No partial state survives.
//  - Illegal state encoding -> START on next clock.
// CONFIGURATION
//  GAME_PAUSE_EN defined: adds pause_btn, q_paused and PAUSED state.
//    PLAYING + pause evt -> PAUSED (pause takes priority over win/fail in that cycle).
//    PAUSED: timer frozen; win/lose/tick/start ignored; pause evt -> PLAYING, no round_start.
//  GAME_PAUSE_EN undefined: ports and state absent; 6-state FSM only.
// TESTING
//  1 reset with start_btn=1 held -> stays START; release, press -> q_playing, lives=3, timer=100, round_start=1 cycle.
//  2 PLAYING, win three times with start presses between -> LEVEL_CLR at level 0,1, then WIN at level=2.
//  3 lose three times -> LIFE_LOST (lives 2), LIFE_LOST (lives 1), GAME_OVER (lives 0); start -> START.
//  4 ROUND_TICKS=4, 4 ticks then hold -> timer 3,2,1,0; next cycle LIFE_LOST; extra ticks don't underflow.
//  5 win & lose asserted same cycle at last level -> WIN; win with timer==0 same cycle -> win taken.
//  6 (GAME_PAUSE_EN) pause at timer=50, ticks+win while paused -> timer=50, state PAUSED; pause -> PLAYING, round_start=0.

Source files
------------

// File: rtl/game_ctrl.sv
// Multi-level, multi-life game-flow controller with a per-round countdown timer.
// Optional PAUSED state is compiled in when GAME_PAUSE_EN is defined.
module game_ctrl #(
    parameter int unsigned NUM_LEVELS  = 3,
    parameter int unsigned NUM_LIVES   = 3,
    parameter int unsigned TIMER_W     = 8,
    parameter int unsigned ROUND_TICKS = 100,
    localparam int unsigned LEVEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int unsigned LIVES_W = $clog2(NUM_LIVES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               tick,
    input  logic               win,
    input  logic               lose,
`ifdef GAME_PAUSE_EN
    input  logic               pause_btn,
    output logic               q_paused,
`endif
    output logic               q_start,
    output logic               q_playing,
    output logic               q_level_clr,
    output logic               q_life_lost,
    output logic               q_game_over,
    output logic               q_win,
    output logic [LEVEL_W-1:0] level,
    output logic [LIVES_W-1:0] lives,
    output logic [TIMER_W-1:0] timer,
    output logic               round_start
);

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_PLAYING   = 3'd1,
        S_LEVEL_CLR = 3'd2,
        S_LIFE_LOST = 3'd3,
        S_GAME_OVER = 3'd4,
`ifdef GAME_PAUSE_EN
        S_PAUSED    = 3'd6,
`endif
        S_WIN       = 3'd5
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(ROUND_TICKS);
    localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(NUM_LIVES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL   = LEVEL_W'(NUM_LEVELS - 1);

    state_t             state, state_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic [LIVES_W-1:0] lives_nxt;
    logic [TIMER_W-1:0] timer_nxt;
    logic               round_start_nxt;
    logic               start_prev;
    logic               start_evt;

    assign start_evt = start_btn & ~start_prev;

`ifdef GAME_PAUSE_EN
    logic pause_prev;
    logic pause_evt;
    assign pause_evt = pause_btn & ~pause_prev;
`endif

    // Next-state and counter update; win beats fail, pause beats both.
    always_comb begin
        state_nxt       = state;
        level_nxt       = level;
        lives_nxt       = lives;
        timer_nxt       = timer;
        round_start_nxt = 1'b0;
        case (state)
            S_START: begin
                if (start_evt) begin
                    state_nxt       = S_PLAYING;
                    level_nxt       = '0;
                    lives_nxt       = LIVES_INIT;
                    timer_nxt       = TIMER_RELOAD;
                    round_start_nxt = 1'b1;
                end
            end
            S_PLAYING: begin
`ifdef GAME_PAUSE_EN
                if (pause_evt) begin
                    state_nxt = S_PAUSED;
                end else
`endif
                if (win) begin
                    state_nxt = (level == LAST_LEVEL) ? S_WIN : S_LEVEL_CLR;
                end else if (lose || (timer == '0)) begin
                    lives_nxt = lives - LIVES_W'(1);
                    state_nxt = (lives == LIVES_W'(1)) ? S_GAME_OVER : S_LIFE_LOST;
                end else if (tick) begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            S_LEVEL_CLR: begin
                if (start_evt) begin
                    state_nxt       = S_PLAYING;
                    level_nxt       = level + LEVEL_W'(1);
                    timer_nxt       = TIMER_RELOAD;
                    round_start_nxt = 1'b1;
                end
            end
            S_LIFE_LOST: begin
                if (start_evt) begin
                    state_nxt       = S_PLAYING;
                    timer_nxt       = TIMER_RELOAD;
                    round_start_nxt = 1'b1;
                end
            end
            S_GAME_OVER, S_WIN: begin
                if (start_evt) state_nxt = S_START;
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED: begin
                if (pause_evt) state_nxt = S_PLAYING;
            end
`endif
            default: begin
                state_nxt = S_START;
                level_nxt = '0;
                lives_nxt = LIVES_INIT;
                timer_nxt = TIMER_RELOAD;
            end
        endcase
    end

    // State, counters and one-hot flags all registered from the next-state values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_START;
            level       <= '0;
            lives       <= LIVES_INIT;
            timer       <= TIMER_RELOAD;
            round_start <= 1'b0;
            start_prev  <= 1'b1;
            q_start     <= 1'b1;
            q_playing   <= 1'b0;
            q_level_clr <= 1'b0;
            q_life_lost <= 1'b0;
            q_game_over <= 1'b0;
            q_win       <= 1'b0;
`ifdef GAME_PAUSE_EN
            pause_prev  <= 1'b1;
            q_paused    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            level       <= level_nxt;
            lives       <= lives_nxt;
            timer       <= timer_nxt;
            round_start <= round_start_nxt;
            start_prev  <= start_btn;
            q_start     <= (state_nxt == S_START);
            q_playing   <= (state_nxt == S_PLAYING);
            q_level_clr <= (state_nxt == S_LEVEL_CLR);
            q_life_lost <= (state_nxt == S_LIFE_LOST);
            q_game_over <= (state_nxt == S_GAME_OVER);
            q_win       <= (state_nxt == S_WIN);
`ifdef GAME_PAUSE_EN
            pause_prev  <= pause_btn;
            q_paused    <= (state_nxt == S_PAUSED);
`endif
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed-vector bench for game_ctrl (default parameters, optional GAME_PAUSE_EN).
module tb_game_ctrl;

    localparam logic [6:0] ST_START = 7'b1000000;
    localparam logic [6:0] ST_PLAY  = 7'b0100000;
    localparam logic [6:0] ST_LCLR  = 7'b0010000;
    localparam logic [6:0] ST_LOST  = 7'b0001000;
    localparam logic [6:0] ST_OVER  = 7'b0000100;
    localparam logic [6:0] ST_WIN   = 7'b0000010;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn, tick, win, lose, pause_drv;
    logic       q_start, q_playing, q_level_clr, q_life_lost, q_game_over, q_win;
    logic       paused_flag;
    logic [1:0] level;
    logic [1:0] lives;
    logic [7:0] timer;
    logic       round_start;
    logic [6:0] flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

`ifdef GAME_PAUSE_EN
    localparam logic [6:0] ST_PSD = 7'b0000001;
    logic pause_btn, q_paused;
    assign pause_btn   = pause_drv;
    assign paused_flag = q_paused;
`else
    assign paused_flag = pause_drv & 1'b0;
`endif

    assign flags = {q_start, q_playing, q_level_clr, q_life_lost, q_game_over, q_win, paused_flag};

    game_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .tick        (tick),
        .win         (win),
        .lose        (lose),
`ifdef GAME_PAUSE_EN
        .pause_btn   (pause_btn),
        .q_paused    (q_paused),
`endif
        .q_start     (q_start),
        .q_playing   (q_playing),
        .q_level_clr (q_level_clr),
        .q_life_lost (q_life_lost),
        .q_game_over (q_game_over),
        .q_win       (q_win),
        .level       (level),
        .lives       (lives),
        .timer       (timer),
        .round_start (round_start)
    );

    typedef struct {
        string      nm;
        logic       s, t, w, l, p;
        logic [6:0] st;
        int         lvl, lv, tm;
        logic       rs;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic s, t, w, l, p,
                       input logic [6:0] st, input int lvl, lv, tm, input logic rs);
        vec_t v;
        v.nm = nm; v.s = s; v.t = t; v.w = w; v.l = l; v.p = p;
        v.st = st; v.lvl = lvl; v.lv = lv; v.tm = tm; v.rs = rs;
        vq.push_back(v);
    endtask

    task automatic drive(input logic s, t, w, l, p);
        start_btn = s; tick = t; win = w; lose = l; pause_drv = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [6:0] st, input int lvl, lv, tm, input logic rs);
        n_vec++;
        if (flags !== st || level !== 2'(lvl) || lives !== 2'(lv) ||
            timer !== 8'(tm) || round_start !== rs) begin
            n_err++;
            $display("FAIL %s: got flags=%b level=%0d lives=%0d timer=%0d rs=%b, want flags=%b level=%0d lives=%0d timer=%0d rs=%b",
                     nm, flags, level, lives, timer, round_start, st, lvl, lv, tm, rs);
        end
    endtask

    task automatic run_table();
        foreach (vq[i]) begin
            drive(vq[i].s, vq[i].t, vq[i].w, vq[i].l, vq[i].p);
            check(vq[i].nm, vq[i].st, vq[i].lvl, vq[i].lv, vq[i].tm, vq[i].rs);
        end
        vq.delete();
    endtask

    initial begin
        reset = 1'b1;
        start_btn = 1'b1; tick = 1'b0; win = 1'b0; lose = 1'b0; pause_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset", ST_START, 0, 3, 100, 1'b0);

        //   name          s  t  w  l  p  state     lvl lv  tm   rs
        add("held",        1, 0, 0, 0, 0, ST_START, 0,  3, 100, 0);
        add("release",     0, 0, 0, 0, 0, ST_START, 0,  3, 100, 0);
        add("go",          1, 0, 0, 0, 0, ST_PLAY,  0,  3, 100, 1);
        add("rs_drop",     0, 0, 0, 0, 0, ST_PLAY,  0,  3, 100, 0);
        add("tick",        0, 1, 0, 0, 0, ST_PLAY,  0,  3,  99, 0);
        add("win_l0",      0, 0, 1, 0, 0, ST_LCLR,  0,  3,  99, 0);
        add("clr_ignore",  0, 1, 1, 1, 0, ST_LCLR,  0,  3,  99, 0);
        add("go_l1",       1, 0, 0, 0, 0, ST_PLAY,  1,  3, 100, 1);
        add("win_l1",      1, 0, 1, 0, 0, ST_LCLR,  1,  3, 100, 0);
        add("clr_rel",     0, 0, 0, 0, 0, ST_LCLR,  1,  3, 100, 0);
        add("go_l2",       1, 0, 0, 0, 0, ST_PLAY,  2,  3, 100, 1);
        add("win_lose_l2", 0, 0, 1, 1, 0, ST_WIN,   2,  3, 100, 0);
        add("win_to_st",   1, 0, 0, 0, 0, ST_START, 2,  3, 100, 0);
        add("st_rel",      0, 0, 0, 0, 0, ST_START, 2,  3, 100, 0);
        add("go_g2",       1, 0, 0, 0, 0, ST_PLAY,  0,  3, 100, 1);
        add("lose1",       0, 0, 0, 1, 0, ST_LOST,  0,  2, 100, 0);
        add("retry1",      1, 0, 0, 0, 0, ST_PLAY,  0,  2, 100, 1);
        add("lose2",       0, 0, 0, 1, 0, ST_LOST,  0,  1, 100, 0);
        add("retry2",      1, 0, 0, 0, 0, ST_PLAY,  0,  1, 100, 1);
        add("lose3",       0, 0, 0, 1, 0, ST_OVER,  0,  0, 100, 0);
        add("over_ignore", 0, 1, 1, 1, 0, ST_OVER,  0,  0, 100, 0);
        add("over_to_st",  1, 0, 0, 0, 0, ST_START, 0,  0, 100, 0);
        add("st_rel2",     0, 0, 0, 0, 0, ST_START, 0,  0, 100, 0);
        run_table();

        // Timer countdown, saturation and timeout-as-fail.
        drive(1, 0, 0, 0, 0);
        check("t_go", ST_PLAY, 0, 3, 100, 1'b1);
        repeat (96) drive(0, 1, 0, 0, 0);
        check("t_at4", ST_PLAY, 0, 3, 4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 0, 0);
            check("t_count", ST_PLAY, 0, 3, 3 - k, 1'b0);
        end
        drive(0, 0, 0, 0, 0);
        check("t_timeout", ST_LOST, 0, 2, 0, 1'b0);
        drive(0, 1, 0, 0, 0);
        check("t_no_under", ST_LOST, 0, 2, 0, 1'b0);

        // Win on the same cycle the expired timer would fail the round.
        drive(1, 0, 0, 0, 0);
        check("t2_go", ST_PLAY, 0, 2, 100, 1'b1);
        repeat (100) drive(0, 1, 0, 0, 0);
        check("t2_zero", ST_PLAY, 0, 2, 0, 1'b0);
        drive(0, 0, 1, 0, 0);
        check("t2_win_t0", ST_LCLR, 0, 2, 0, 1'b0);
        drive(1, 0, 0, 0, 0);
        check("t2_next", ST_PLAY, 1, 2, 100, 1'b1);

`ifdef GAME_PAUSE_EN
        repeat (50) drive(0, 1, 0, 0, 0);
        check("p_at50", ST_PLAY, 1, 2, 50, 1'b0);
        drive(0, 0, 1, 0, 1);
        check("p_enter", ST_PSD, 1, 2, 50, 1'b0);
        drive(1, 1, 1, 1, 0);
        check("p_frozen", ST_PSD, 1, 2, 50, 1'b0);
        drive(0, 0, 0, 0, 1);
        check("p_resume", ST_PLAY, 1, 2, 50, 1'b0);
        drive(0, 0, 0, 0, 0);
`endif

        // Asynchronous reset between clock edges.
        #3 reset = 1'b1;
        #1 check("async_rst", ST_START, 0, 3, 100, 1'b0);
        #1 reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        check("post_rst", ST_START, 0, 3, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
